// File: rtl/dt_param_if.sv
// Port bundle of the dt_param distance-transform engine: run control,
// stimulus ROM read port and result RAM read/write port.
interface dt_param_if #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int STI_W  = 16,
   parameter int DIST_W = 8
);
   localparam int PW  = $clog2(IMG_W * IMG_H);
   localparam int SAW = $clog2(IMG_W * IMG_H / STI_W);

   // start is a one-cycle request taken only while idle; busy covers the run and
   // done pulses once at its end. Memory read data is combinational from the
   // address in the same cycle; a RAM write commits at the clock edge with res_wr.
   logic              start;
   logic              mode;
   logic              busy;
   logic              done;
   logic              sti_rd;
   logic [SAW-1:0]    sti_addr;
   logic [STI_W-1:0]  sti_di;
   logic              res_rd;
   logic              res_wr;
   logic [PW-1:0]     res_addr;
   logic [DIST_W-1:0] res_do;
   logic [DIST_W-1:0] res_di;
   logic [2:0]        dbg_state;

   modport master (
      input  start, mode, sti_di, res_di,
      output busy, done, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do, dbg_state
   );

   modport slave (
      output start, mode, sti_di, res_di,
      input  busy, done, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do, dbg_state
   );
endinterface

// File: rtl/dt_param.sv
// Two-pass chamfer distance transform (chessboard or city-block) over a packed
// binary image in ROM, producing a saturating per-pixel distance map in RAM.
module dt_param #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int STI_W  = 16,
   parameter int DIST_W = 8
) (
   input logic       clk,
   input logic       reset,
   dt_param_if.master bus
);
   localparam int NPIX = IMG_W * IMG_H;
   localparam int PW   = $clog2(NPIX);
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = PW - CW;
   localparam int SBW  = $clog2(STI_W);
   localparam logic [PW-1:0]     P_LAST   = PW'(NPIX - 1);
   localparam logic [PW-1:0]     ROW_STEP = PW'(IMG_W);
   localparam logic [PW-1:0]     ONE      = PW'(1);
   localparam logic [CW-1:0]     C_LAST   = CW'(IMG_W - 1);
   localparam logic [RW-1:0]     R_LAST   = RW'(IMG_H - 1);
   localparam logic [DIST_W-1:0] MAXD     = '1;

   typedef enum logic [2:0] {IDLE, F_PIX, F_NB, F_WR, B_PIX, B_NB, B_WR, FIN} state_t;

   state_t            state;
   logic              mode_q;
   logic [PW-1:0]     p;
   logic [1:0]        slot;
   logic [DIST_W-1:0] m;

   function automatic logic [DIST_W-1:0] inc(input logic [DIST_W-1:0] x);
      return (x == MAXD) ? x : x + DIST_W'(1);
   endfunction

   // Slots 0..3 are W,NW,N,NE going forward and E,SW,S,SE going backward.
   function automatic logic slot_ok(input logic bwd_i, input logic md,
                                    input logic [1:0] s, input logic [PW-1:0] pp);
      logic lft, rgt, top, bot, ok;
      lft = (pp[CW-1:0] != '0);
      rgt = (pp[CW-1:0] != C_LAST);
      top = (pp[PW-1:CW] != '0);
      bot = (pp[PW-1:CW] != R_LAST);
      if (md && s[0]) ok = 1'b0;
      else if (!bwd_i) begin
         case (s)
            2'd0:    ok = lft;
            2'd1:    ok = top && lft;
            2'd2:    ok = top;
            default: ok = top && rgt;
         endcase
      end else begin
         case (s)
            2'd0:    ok = rgt;
            2'd1:    ok = bot && lft;
            2'd2:    ok = bot;
            default: ok = bot && rgt;
         endcase
      end
      return ok;
   endfunction

   function automatic logic [PW-1:0] slot_addr(input logic bwd_i, input logic [1:0] s,
                                               input logic [PW-1:0] pp);
      logic [PW-1:0] a;
      if (!bwd_i) begin
         case (s)
            2'd0:    a = pp - ONE;
            2'd1:    a = pp - ROW_STEP - ONE;
            2'd2:    a = pp - ROW_STEP;
            default: a = pp - ROW_STEP + ONE;
         endcase
      end else begin
         case (s)
            2'd0:    a = pp + ONE;
            2'd1:    a = pp + ROW_STEP - ONE;
            2'd2:    a = pp + ROW_STEP;
            default: a = pp + ROW_STEP + ONE;
         endcase
      end
      return a;
   endfunction

   // Returns {found, slot} for the lowest in-image slot at or above 'from'.
   function automatic logic [2:0] scan(input logic bwd_i, input logic md,
                                       input logic [2:0] from, input logic [PW-1:0] pp);
      logic [2:0] r;
      r = 3'b000;
      for (int s = 3; s >= 0; s--)
         if (s >= int'(from) && slot_ok(bwd_i, md, 2'(s), pp)) r = {1'b1, 2'(s)};
      return r;
   endfunction

   logic              bwd;
   logic [2:0]        first_nb;
   logic [2:0]        after_nb;
   logic [SBW-1:0]    bit_sel;
   logic              obj;
   logic [DIST_W-1:0] bwd_cand;
   logic [DIST_W-1:0] fwd_min;
   logic [DIST_W-1:0] bwd_min;

   always_comb begin
      bwd      = (state == B_PIX) || (state == B_NB);
      first_nb = scan(bwd, mode_q, 3'd0, p);
      after_nb = scan(bwd, mode_q, {1'b0, slot} + 3'd1, p);
      bit_sel  = ~p[SBW-1:0];
      obj      = bus.sti_di[bit_sel];
      bwd_cand = inc(bus.res_di);
      fwd_min  = (bus.res_di < m) ? bus.res_di : m;
      bwd_min  = (bwd_cand < m) ? bwd_cand : m;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         mode_q <= 1'b0;
         p      <= '0;
         slot   <= '0;
         m      <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               mode_q <= bus.mode;
               p      <= '0;
               state  <= F_PIX;
            end
            F_PIX: begin
               if (obj) begin
                  m     <= MAXD;
                  slot  <= first_nb[1:0];
                  state <= first_nb[2] ? F_NB : F_WR;
               end else if (p == P_LAST) state <= B_PIX;
               else p <= p + ONE;
            end
            F_NB: begin
               m    <= fwd_min;
               slot <= after_nb[1:0];
               if (!after_nb[2]) state <= F_WR;
            end
            F_WR: begin
               if (p == P_LAST) state <= B_PIX;
               else begin
                  p     <= p + ONE;
                  state <= F_PIX;
               end
            end
            B_PIX: begin
               if (bus.res_di == '0) begin
                  if (p == '0) state <= FIN;
                  else p <= p - ONE;
               end else begin
                  m     <= bus.res_di;
                  slot  <= first_nb[1:0];
                  state <= first_nb[2] ? B_NB : B_WR;
               end
            end
            B_NB: begin
               m    <= bwd_min;
               slot <= after_nb[1:0];
               if (!after_nb[2]) state <= B_WR;
            end
            B_WR: begin
               if (p == '0) state <= FIN;
               else begin
                  p     <= p - ONE;
                  state <= B_PIX;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Background writes must land in the same cycle the ROM bit is seen, so the
   // memory strobes decode from state; reset forces every output quiet at once.
   always_comb begin
      bus.sti_rd    = 1'b0;
      bus.sti_addr  = '0;
      bus.res_rd    = 1'b0;
      bus.res_wr    = 1'b0;
      bus.res_addr  = '0;
      bus.res_do    = '0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.dbg_state = state;
      if (!reset) begin
         bus.busy = (state != IDLE) && (state != FIN);
         bus.done = (state == FIN);
         case (state)
            F_PIX: begin
               bus.sti_rd   = 1'b1;
               bus.sti_addr = p[PW-1:SBW];
               bus.res_addr = p;
               bus.res_wr   = !obj;
            end
            F_NB, B_NB: begin
               bus.res_rd   = 1'b1;
               bus.res_addr = slot_addr(bwd, slot, p);
            end
            F_WR: begin
               bus.res_wr   = 1'b1;
               bus.res_addr = p;
               bus.res_do   = inc(m);
            end
            B_PIX: begin
               bus.res_rd   = 1'b1;
               bus.res_addr = p;
            end
            B_WR: begin
               bus.res_wr   = 1'b1;
               bus.res_addr = p;
               bus.res_do   = m;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dt_param.sv
// Bench for dt_param: two instances (8x8/8-bit and 16x16/3-bit) checked against
// a brute-force nearest-background distance model and a cycle-cost model.
module tb_dt_param;
   localparam int A_W = 8,  A_H = 8,  A_S = 8,  A_D = 8;
   localparam int B_W = 16, B_H = 16, B_S = 16, B_D = 3;
   localparam int A_N = A_W * A_H;
   localparam int B_N = B_W * B_H;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dt_param_if #(.IMG_W(A_W), .IMG_H(A_H), .STI_W(A_S), .DIST_W(A_D)) ia ();
   dt_param_if #(.IMG_W(B_W), .IMG_H(B_H), .STI_W(B_S), .DIST_W(B_D)) ib ();

   dt_param #(.IMG_W(A_W), .IMG_H(A_H), .STI_W(A_S), .DIST_W(A_D)) dut_a (
      .clk(clk), .reset(reset), .bus(ia));
   dt_param #(.IMG_W(B_W), .IMG_H(B_H), .STI_W(B_S), .DIST_W(B_D)) dut_b (
      .clk(clk), .reset(reset), .bus(ib));

   logic [A_S-1:0] rom_a [A_N/A_S];
   logic [A_D-1:0] ram_a [A_N];
   logic [B_S-1:0] rom_b [B_N/B_S];
   logic [B_D-1:0] ram_b [B_N];

   assign ia.sti_di = rom_a[ia.sti_addr];
   assign ia.res_di = ram_a[ia.res_addr];
   assign ib.sti_di = rom_b[ib.sti_addr];
   assign ib.res_di = ram_b[ib.res_addr];

   always @(posedge clk) begin
      if (ia.res_wr) ram_a[ia.res_addr] <= ia.res_do;
      if (ib.res_wr) ram_b[ib.res_addr] <= ib.res_do;
   end

   int sel = 0;
   logic m_busy, m_done, m_sti, m_rd, m_wr;
   always_comb begin
      if (sel == 0) {m_busy, m_done, m_sti, m_rd, m_wr} = {ia.busy, ia.done, ia.sti_rd, ia.res_rd, ia.res_wr};
      else          {m_busy, m_done, m_sti, m_rd, m_wr} = {ib.busy, ib.done, ib.sti_rd, ib.res_rd, ib.res_wr};
   end

   int busy_cyc, done_cnt, sti_cnt, clash;
   always @(negedge clk) begin
      if (m_busy) busy_cyc++;
      if (m_done) done_cnt++;
      if (m_sti) sti_cnt++;
      if ((m_rd && m_wr) || (m_done && m_busy)) clash++;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   bit img [B_N];
   int exp_map [B_N];

   function automatic int nvalid(input int w, input int h, input int r, input int c,
                                 input bit md, input bit bwd);
      int dr[4];
      int dc[4];
      int n, rr, cc;
      dr = '{0, -1, -1, -1};
      dc = '{-1, -1, 0, 1};
      n = 0;
      for (int k = 0; k < 4; k++) begin
         if (md && (k == 1 || k == 3)) continue;
         rr = bwd ? r - dr[k] : r + dr[k];
         cc = bwd ? c - dc[k] : c + dc[k];
         if (rr >= 0 && rr < h && cc >= 0 && cc < w) n++;
      end
      return n;
   endfunction

   // Distance to nearest background pixel under the metric, clamped at maxd.
   task automatic build_model(input int w, input int h, input int maxd, input bit md,
                              output int cyc);
      int best, d, dr, dc;
      cyc = 0;
      for (int p = 0; p < w * h; p++) begin
         if (!img[p]) exp_map[p] = 0;
         else begin
            best = maxd;
            for (int q = 0; q < w * h; q++) begin
               if (img[q]) continue;
               dr = (p / w > q / w) ? p / w - q / w : q / w - p / w;
               dc = (p % w > q % w) ? p % w - q % w : q % w - p % w;
               d = md ? dr + dc : ((dr > dc) ? dr : dc);
               if (d < best) best = d;
            end
            exp_map[p] = best;
         end
         cyc += img[p] ? 2 + nvalid(w, h, p / w, p % w, md, 1'b0) : 1;
         cyc += (exp_map[p] == 0) ? 1 : 2 + nvalid(w, h, p / w, p % w, md, 1'b1);
      end
   endtask

   task automatic load(input int s);
      if (s == 0) begin
         for (int p = 0; p < A_N; p++) begin
            rom_a[p / A_S][A_S - 1 - p % A_S] = img[p];
            ram_a[p] = A_D'($urandom);
         end
      end else begin
         for (int p = 0; p < B_N; p++) begin
            rom_b[p / B_S][B_S - 1 - p % B_S] = img[p];
            ram_b[p] = B_D'($urandom);
         end
      end
   endtask

   task automatic drive(input int s, input logic st, input logic md);
      if (s == 0) begin ia.start = st; ia.mode = md; end
      else        begin ib.start = st; ib.mode = md; end
   endtask

   task automatic run(input string name, input int s, input bit md, input bit poke);
      int w, h, n, cyc;
      int got;
      w = (s == 0) ? A_W : B_W;
      h = (s == 0) ? A_H : B_H;
      n = w * h;
      build_model(w, h, (s == 0) ? 255 : 7, md, cyc);
      load(s);
      sel = s;
      @(negedge clk); #1;
      busy_cyc = 0; done_cnt = 0; sti_cnt = 0; clash = 0;
      drive(s, 1'b1, md);
      @(negedge clk); #1;
      drive(s, 1'b0, ~md);
      for (int k = 0; k < 30 * n && done_cnt == 0; k++) begin
         @(negedge clk); #1;
         if (poke && k == 10) drive(s, 1'b1, ~md);
         if (poke && k == 11) drive(s, 1'b0, md);
      end
      drive(s, 1'b0, md);
      repeat (4) @(negedge clk);
      check({name, " done pulses"}, 64'(done_cnt), 64'd1);
      check({name, " busy cycles"}, 64'(busy_cyc), 64'(cyc));
      check({name, " rom reads"}, 64'(sti_cnt), 64'(n));
      check({name, " strobe clash"}, 64'(clash), 64'd0);
      for (int p = 0; p < n; p++) begin
         got = (s == 0) ? int'(ram_a[p]) : int'(ram_b[p]);
         check($sformatf("%s p%0d", name, p), 64'(got), 64'(exp_map[p]));
      end
   endtask

   task automatic set_img(input int n, input int bg_div);
      for (int p = 0; p < n; p++) img[p] = (bg_div == 0) ? 1'b0 : ($urandom_range(0, bg_div - 1) != 0);
   endtask

   initial begin
      int dv;
      ia.start = 1'b0; ia.mode = 1'b0;
      ib.start = 1'b0; ib.mode = 1'b0;
      repeat (3) @(negedge clk);
      check("reset outputs a", 64'({ia.busy, ia.done, ia.sti_rd, ia.res_rd, ia.res_wr,
                                    ia.sti_addr, ia.res_addr, ia.res_do}), 64'd0);
      check("reset outputs b", 64'({ib.busy, ib.done, ib.sti_rd, ib.res_rd, ib.res_wr,
                                    ib.sti_addr, ib.res_addr, ib.res_do}), 64'd0);
      #1 reset = 1'b0;
      @(negedge clk);
      check("idle busy", 64'({ia.busy, ia.done, ib.busy, ib.done}), 64'd0);

      set_img(A_N, 0);
      run("t1 bg", 0, 1'b0, 1'b0);

      for (int p = 0; p < A_N; p++) img[p] = (p != 0);
      run("t2 chess", 0, 1'b0, 1'b0);
      check("t2 (7,7)", 64'(ram_a[63]), 64'd7);
      check("t2 (3,5)", 64'(ram_a[29]), 64'd5);
      check("t2 (0,1)", 64'(ram_a[1]), 64'd1);

      run("t3 city", 0, 1'b1, 1'b0);
      check("t3 (7,7)", 64'(ram_a[63]), 64'd14);
      check("t3 (3,5)", 64'(ram_a[29]), 64'd8);
      check("t3 (1,1)", 64'(ram_a[9]), 64'd2);

      for (int p = 0; p < A_N; p++) img[p] = 1'b1;
      run("t4 obj m0", 0, 1'b0, 1'b0);
      check("t4 (4,4)", 64'(ram_a[36]), 64'd255);
      run("t4 obj m1", 0, 1'b1, 1'b0);

      for (int p = 0; p < B_N; p++) img[p] = (p != 0);
      run("t5 sat", 1, 1'b1, 1'b0);
      check("t5 (1,2)", 64'(ram_b[18]), 64'd3);
      check("t5 (15,15)", 64'(ram_b[255]), 64'd7);

      // Abort a run part-way through the forward pass, then rerun cleanly.
      for (int p = 0; p < A_N; p++) img[p] = (p != 0);
      load(0);
      sel = 0;
      @(negedge clk); #1;
      drive(0, 1'b1, 1'b1);
      @(negedge clk); #1;
      drive(0, 1'b0, 1'b1);
      repeat (30) @(negedge clk);
      #1 reset = 1'b1;
      #1 check("t6 outputs in reset", 64'({ia.busy, ia.done, ia.sti_rd, ia.res_rd, ia.res_wr,
                                           ia.sti_addr, ia.res_addr, ia.res_do}), 64'd0);
      @(negedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("t6 idle after reset", 64'({ia.busy, ia.done}), 64'd0);
      run("t6 rerun", 0, 1'b0, 1'b1);
      check("t6 (7,7)", 64'(ram_a[63]), 64'd7);

      for (int i = 0; i < 4; i++) begin
         dv = $urandom_range(2, 12);
         set_img(A_N, dv);
         run($sformatf("rnd a%0d", i), 0, 1'($urandom_range(0, 1)), 1'(i == 1));
      end
      for (int i = 0; i < 2; i++) begin
         dv = $urandom_range(8, 40);
         set_img(B_N, dv);
         run($sformatf("rnd b%0d", i), 1, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dt_param.md
Name: dt_param

Overview:
Parametrised two-pass chamfer distance-transform engine, the successor to the fixed 128x128 DT block. It reads a packed binary image from the stimulus ROM (sti_*) and writes a per-pixel distance map to the result RAM (res_*). Image size, ROM word width and distance width are parameters. A mode input selects the chessboard (8-neighbour) or city-block (4-neighbour) metric. Out-of-image neighbours are excluded rather than treated as background, and start/busy/done handshaking allows repeated runs.

Parameters:
IMG_W, 128, image width in pixels; power of 2, multiple of STI_W
IMG_H, 128, image height in pixels; power of 2
STI_W, 16, ROM word width; pixel bits packed MSB-first
DIST_W, 8, distance width; MAXD = 2^DIST_W-1 means "unreached", saturating

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0=chessboard (8-nbr), 1=city-block (4-nbr); latched at start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at end of backward pass
sti_rd  out  1  ROM read enable
sti_addr  out  log2(IMG_W*IMG_H/STI_W)  ROM word address
sti_di  in  STI_W  ROM data, combinational (same cycle as address)
res_rd  out  1  RAM read enable
res_wr  out  1  RAM write enable; write at clock edge
res_addr  out  log2(IMG_W*IMG_H)  pixel index p = row*IMG_W+col
res_do  out  DIST_W  RAM write data
res_di  in  DIST_W  RAM read data, combinational

Behaviour:
- Reset: state IDLE. busy, done, sti_rd, res_rd and res_wr are 0. sti_addr, res_addr and res_do are 0. Counters are cleared. Reset mid-run aborts and leaves RAM contents undefined.
- Only one of res_rd/res_wr is high in any cycle. Outside an access, addresses are don't-care but must be driven.
- Pixel bit: sti_addr = p/STI_W; object = sti_di[STI_W-1 - p%STI_W].
- Saturating increment: inc(x) = MAXD if x==MAXD, else x+1.
- States: IDLE, F_PIX, F_NB, F_WR, B_PIX, B_NB, B_WR, FIN.
- IDLE: when start=1, latch mode, set p=0, go to F_PIX. start while busy is ignored.
- F_PIX (sti_rd=1): background pixel -> res_wr=1, res_do=0 in this same cycle, then advance p. Object pixel -> go to F_NB.
- F_NB: read forward neighbours one per cycle, skipping any that lie outside the image (no cycle spent on them).
  - Order, mode0: W, NW, N, NE.
  - Order, mode1: W, N.
  - Running minimum m starts at MAXD.
- F_WR: write inc(m) at p (res_wr=1). If no neighbour was valid, the written value is MAXD.
- Forward cycle cost: background pixel 1 cycle; object pixel 1 + valid neighbours + 1.
- After p = IMG_W*IMG_H-1, go to B_PIX with p = last pixel index.
- B_PIX (res_rd=1 at p): res_di==0 -> skip, decrement p. Otherwise cur=res_di and m=cur; go to B_NB.
- B_NB: read valid backward neighbours, one per cycle.
  - Order, mode0: E, SW, S, SE.
  - Order, mode1: E, S.
  - For each: m = min(m, inc(res_di)).
- B_WR: write m at p. The write happens even if m==cur, to give fixed timing.
- After p = 0 completes, go to FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Row wrap: W/E/NW/NE/SW/SE neighbours must never wrap across a row boundary. Column 0 has no W/NW/SW; column IMG_W-1 has no E/NE/SE.
- Address arithmetic is done at full width with no modulo aliasing.

Test Plan:
1. IMG_W=IMG_H=8, STI_W=8, all-background image -> all 64 words are 0. Forward pass takes exactly 64 cycles; done pulses once.
2. 8x8, mode0, object everywhere except (0,0) -> res[r][c] = max(r,c): (7,7)=7, (3,5)=5, (0,1)=1.
3. Same image, mode1 -> res[r][c] = r+c: (7,7)=14, (3,5)=8, (1,1)=2.
4. 8x8, all-object image, either mode -> every word is 255 (MAXD); done still asserted.
5. IMG 16x16, STI_W=16, DIST_W=3, mode1, only (0,0) background -> (1,2)=3, (15,15)=7 (saturated), no wrap to 0.
6. Assert reset for 1 cycle mid forward pass, then start again with mode0 on test-2 image -> outputs are 0 during reset, and the final map matches test 2. A start pulse issued while busy is ignored (only one done pulse).
